// File: rtl/rr_mux_nto1.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_nto1
// Purpose  : N-channel, WIDTH-bit stream multiplexer with valid/ready
//            handshakes, a registered output stage, and two arbitration
//            modes: fixed software select or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_nto1 #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    // Valid vector padded to the full select range so that any select value,
    // including those beyond CHANNELS-1, indexes a real bit (reads as 0).
    localparam int c_SLOTS = 1 << SEL_W;

    logic [c_SLOTS-1:0] w_valid_ext;
    logic               w_load_en;
    logic               w_fix_valid;
    logic               w_rr_valid;
    logic [SEL_W-1:0]   w_rr_grant;
    logic               w_grant_valid;
    logic [SEL_W-1:0]   w_grant;
    logic [WIDTH-1:0]   w_grant_data;
    logic               w_xfer;
    int                 w_idx;

    logic [SEL_W-1:0]   r_ptr;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_chan;

    assign w_valid_ext = c_SLOTS'(in_valid);

    // The output register may take a new word when empty or being drained.
    assign w_load_en = !r_out_valid | out_ready;

    // Fixed mode: the selected channel wins if it exists and is valid.
    assign w_fix_valid = (int'(select) < CHANNELS) & w_valid_ext[select];

    // Round-robin scan starting at the pointer; scanning from the far end
    // back toward the pointer lets the nearest valid channel overwrite.
    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_grant = '0;
        w_idx      = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end
            if (w_valid_ext[SEL_W'(w_idx)]) begin
                w_rr_valid = 1'b1;
                w_rr_grant = SEL_W'(w_idx);
            end
        end
    end

    assign w_grant_valid = mode ? w_rr_valid : w_fix_valid;
    assign w_grant       = mode ? w_rr_grant : select;

    // Steer the granted channel's data toward the output register.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant always completes a transfer because ready is only offered to
    // the granted channel, and only when that channel is valid.
    assign w_xfer = !reset & w_load_en & w_grant_valid;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ready
            assign in_ready[i] = w_xfer & (w_grant == SEL_W'(i));
        end
    endgenerate

    // Output stage and round-robin pointer; data/chan hold on an empty load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_load_en) begin
                r_out_valid <= w_grant_valid;
                if (w_grant_valid) begin
                    r_out_data <= w_grant_data;
                    r_out_chan <= w_grant;
                end
            end
            if (w_xfer & mode) begin
                r_ptr <= (w_grant == SEL_W'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_nto1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_nto1
// Purpose  : Self-checking bench for rr_mux_nto1; drives a 4-channel and a
//            3-channel instance with shared controls and compares both
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_nto1;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  select;
    logic        out_ready;

    logic [15:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic [3:0]  out_data4;
    logic        out_valid4;
    logic [1:0]  out_chan4;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [3:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_chan3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state for each instance
    int m4_valid, m4_data, m4_chan, m4_ptr;
    int m3_valid, m3_data, m3_chan, m3_ptr;

    always #5 clk = ~clk;

    rr_mux_nto1 #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .reset(reset), .mode(mode), .select(select),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_chan(out_chan4),
        .out_ready(out_ready)
    );

    rr_mux_nto1 #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .mode(mode), .select(select),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_chan(out_chan3),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Which channel wins this cycle, or -1 for none.
    function automatic int arb(input int n, input int md, input int sel,
                               input int v, input int ptr);
        if (md == 0) begin
            if (sel < n && ((v >> sel) % 2) == 1) return sel;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (((v >> c) % 2) == 1) return c;
        end
        return -1;
    endfunction

    // One clock: check outputs and ready against the model, then advance it.
    task automatic cycle();
        int g4, g3, rdy4, rdy3, ld4, ld3;
        #3;
        g4  = arb(4, int'(mode), int'(select), int'(in_valid4), m4_ptr);
        g3  = arb(3, int'(mode), int'(select), int'(in_valid3), m3_ptr);
        ld4 = (m4_valid == 0 || out_ready) ? 1 : 0;
        ld3 = (m3_valid == 0 || out_ready) ? 1 : 0;
        rdy4 = (!reset && ld4 == 1 && g4 >= 0) ? (1 << g4) : 0;
        rdy3 = (!reset && ld3 == 1 && g3 >= 0) ? (1 << g3) : 0;

        chk("ready4", int'(in_ready4), rdy4);
        chk("valid4", int'(out_valid4), m4_valid);
        chk("data4",  int'(out_data4),  m4_data);
        chk("chan4",  int'(out_chan4),  m4_chan);
        chk("ready3", int'(in_ready3), rdy3);
        chk("valid3", int'(out_valid3), m3_valid);
        chk("data3",  int'(out_data3),  m3_data);
        chk("chan3",  int'(out_chan3),  m3_chan);

        @(posedge clk);
        if (reset) begin
            m4_valid = 0; m4_data = 0; m4_chan = 0; m4_ptr = 0;
            m3_valid = 0; m3_data = 0; m3_chan = 0; m3_ptr = 0;
        end else begin
            if (ld4 == 1) begin
                m4_valid = (g4 >= 0) ? 1 : 0;
                if (g4 >= 0) begin
                    m4_data = (int'(in_data4) >> (4 * g4)) % 16;
                    m4_chan = g4;
                    if (mode) m4_ptr = (g4 + 1) % 4;
                end
            end
            if (ld3 == 1) begin
                m3_valid = (g3 >= 0) ? 1 : 0;
                if (g3 >= 0) begin
                    m3_data = (int'(in_data3) >> (4 * g3)) % 16;
                    m3_chan = g3;
                    if (mode) m3_ptr = (g3 + 1) % 3;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic rst, input logic md, input logic [1:0] sel,
                         input logic [15:0] d, input logic [3:0] v,
                         input logic ordy);
        reset     = rst;
        mode      = md;
        select    = sel;
        in_data4  = d;
        in_data3  = d[11:0];
        in_valid4 = v;
        in_valid3 = v[2:0];
        out_ready = ordy;
    endtask

    initial begin
        m4_valid = 0; m4_data = 0; m4_chan = 0; m4_ptr = 0;
        m3_valid = 0; m3_data = 0; m3_chan = 0; m3_ptr = 0;
        drive(1'b1, 1'b0, 2'd0, 16'h4321, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        // Reset held two cycles with everything valid
        cycle();
        cycle();

        // Fixed select of channel 2, then channel 2 drops valid
        drive(1'b0, 1'b0, 2'd2, 16'h0A00, 4'b1111, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 2'd2, 16'h0A00, 4'b1011, 1'b1);
        cycle();
        cycle();

        // Select beyond the 3-channel instance's range
        drive(1'b0, 1'b0, 2'd3, 16'h7654, 4'b1111, 1'b1);
        cycle();
        cycle();

        // Round-robin, all valid, data 1..4
        drive(1'b0, 1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1);
        repeat (6) cycle();

        // Round-robin with only channels 1 and 3 valid
        drive(1'b0, 1'b1, 2'd0, 16'h4321, 4'b1010, 1'b1);
        repeat (5) cycle();

        // Backpressure for three cycles, then release
        drive(1'b0, 1'b0, 2'd1, 16'h0050, 4'b1111, 1'b1);
        cycle();
        drive(1'b0, 1'b1, 2'd1, 16'h9876, 4'b1111, 1'b0);
        repeat (3) cycle();
        drive(1'b0, 1'b1, 2'd1, 16'h9876, 4'b1111, 1'b1);
        repeat (2) cycle();

        // Reset pulse mid-stream, then round-robin restarts at channel 0
        drive(1'b1, 1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1);
        cycle();
        drive(1'b0, 1'b1, 2'd0, 16'h4321, 4'b1111, 1'b1);
        repeat (4) cycle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  16'($urandom),
                  4'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
